// File: rtl/bram_frame_loader.sv
// bram_frame_loader: buffers one frame of samples, bursts it into the
// beamformer BRAM, then sequences the start pulse and playback window.
module bram_frame_loader #(
   parameter int DATA_W    = 4,
   parameter int DEPTH     = 8,
   parameter int GAP       = 40,
   parameter int START_LEN = 4,
   parameter int PLAY_LEN  = 16
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              abort,
   output logic              bram_load,
   output logic              bram_start,
   output logic [DATA_W-1:0] bram_data,
   output logic              busy,
   output logic              frame_done,
   output logic [7:0]        frame_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   localparam int T1 = (GAP > START_LEN) ? GAP : START_LEN;
   localparam int TMAX = (T1 > PLAY_LEN) ? T1 : PLAY_LEN;
   localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [CW-1:0] WR_LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] RD_END  = CW'(DEPTH);
   localparam logic [TW-1:0] GAP_END   = TW'(GAP - 1);
   localparam logic [TW-1:0] START_END = TW'(START_LEN - 1);
   localparam logic [TW-1:0] PLAY_END  = TW'(PLAY_LEN - 1);

   localparam logic [2:0] S_FILL  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_PLAY  = 3'd4;

   logic [2:0]        state, state_n;
   logic [CW-1:0]     wr_cnt, wr_n;
   logic [CW-1:0]     rd_idx, rd_n;
   logic [TW-1:0]     timer, tm_n;
   logic              ready_n, load_n, start_n, done_n, busy_n;
   logic [DATA_W-1:0] data_n;
   logic [7:0]        count_n;
   logic              wr_en;
   logic [DATA_W-1:0] mem [DEPTH];

   always_comb begin
      state_n = state;
      wr_n    = wr_cnt;
      rd_n    = rd_idx;
      tm_n    = timer;
      ready_n = 1'b0;
      load_n  = 1'b0;
      start_n = 1'b0;
      done_n  = 1'b0;
      data_n  = '0;
      count_n = frame_count;
      wr_en   = 1'b0;
      if (abort) begin
         // abort wins over any handshake on the same edge
         state_n = S_FILL;
         wr_n    = '0;
         rd_n    = '0;
         tm_n    = '0;
         ready_n = 1'b1;
      end else begin
         unique case (state)
            S_FILL: begin
               ready_n = 1'b1;
               if (in_valid && in_ready) begin
                  wr_en = 1'b1;
                  wr_n  = wr_cnt + 1'b1;
                  if (wr_cnt == WR_LAST) begin
                     state_n = S_LOAD;
                     ready_n = 1'b0;
                     load_n  = 1'b1;
                     data_n  = mem[0];
                     rd_n    = CW'(1);
                  end
               end
            end
            S_LOAD: begin
               if (rd_idx == RD_END) begin
                  state_n = S_WAIT;
                  tm_n    = '0;
               end else begin
                  load_n = 1'b1;
                  data_n = mem[rd_idx[IW-1:0]];
                  rd_n   = rd_idx + 1'b1;
               end
            end
            S_WAIT: begin
               if (timer == GAP_END) begin
                  state_n = S_START;
                  start_n = 1'b1;
                  tm_n    = '0;
               end else begin
                  tm_n = timer + 1'b1;
               end
            end
            S_START: begin
               if (timer == START_END) begin
                  state_n = S_PLAY;
                  tm_n    = '0;
               end else begin
                  start_n = 1'b1;
                  tm_n    = timer + 1'b1;
               end
            end
            S_PLAY: begin
               if (timer == PLAY_END) begin
                  state_n = S_FILL;
                  done_n  = 1'b1;
                  count_n = frame_count + 1'b1;
                  ready_n = 1'b1;
                  wr_n    = '0;
                  rd_n    = '0;
                  tm_n    = '0;
               end else begin
                  tm_n = timer + 1'b1;
               end
            end
            default: begin
               state_n = S_FILL;
               wr_n    = '0;
               rd_n    = '0;
               tm_n    = '0;
            end
         endcase
      end
      busy_n = (state_n != S_FILL);
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         state       <= S_FILL;
         wr_cnt      <= '0;
         rd_idx      <= '0;
         timer       <= '0;
         in_ready    <= 1'b0;
         bram_load   <= 1'b0;
         bram_start  <= 1'b0;
         bram_data   <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_n;
         wr_cnt      <= wr_n;
         rd_idx      <= rd_n;
         timer       <= tm_n;
         in_ready    <= ready_n;
         bram_load   <= load_n;
         bram_start  <= start_n;
         bram_data   <= data_n;
         busy        <= busy_n;
         frame_done  <= done_n;
         frame_count <= count_n;
      end
   end

   // sample store needs no reset; contents past wr_cnt are never read
   always_ff @(posedge clock) begin
      if (rst && wr_en)
         mem[wr_cnt[IW-1:0]] <= in_data;
   end

endmodule

// File: tb/tb_bram_frame_loader.sv
// tb_bram_frame_loader: directed checks of fill, load burst, start timing,
// abort handling, frame counter wrap and mid-frame reset.
module tb_bram_frame_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       abort;
   logic       bram_load;
   logic       bram_start;
   logic [3:0] bram_data;
   logic       busy;
   logic       frame_done;
   logic [7:0] frame_count;

   int checks = 0;
   int errors = 0;

   bram_frame_loader dut (
      .clock       (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .abort       (abort),
      .bram_load   (bram_load),
      .bram_start  (bram_start),
      .bram_data   (bram_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_sig(input string tag, input bit on_done,
                           input logic lvl);
      int n = 0;
      while (((on_done ? frame_done : bram_start) !== lvl) && n < 300) begin
         tick();
         n++;
      end
      chk(tag, on_done ? frame_done : bram_start, lvl);
   endtask

   initial begin
      int n;
      logic [3:0] v;

      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      abort = 1'b0;
      tick();
      tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load", bram_load, 0);
      chk("rst_start", bram_start, 0);
      chk("rst_data", bram_data, 0);
      chk("rst_count", frame_count, 0);
      rst = 1'b1;
      tick();
      chk("ready_after_rst", in_ready, 1);

      // test 1: stream 1..8 with valid held
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data = 4'(i);
         tick();
         if (i < 8) chk("t1_fill_ready", in_ready, 1);
      end
      in_data = 4'd9;
      chk("t1_ready_drop", in_ready, 0);
      for (int k = 0; k < 8; k++) begin
         chk("t1_load", bram_load, 1);
         chk("t1_data", bram_data, k + 1);
         tick();
      end
      in_valid = 1'b0;
      chk("t1_load_off", bram_load, 0);
      chk("t1_data_off", bram_data, 0);
      chk("t1_busy", busy, 1);

      // test 2: gap, start pulse, play window
      n = 0;
      while (!bram_start && n < 100) begin
         tick();
         n++;
      end
      chk("t2_gap", n, 40);
      n = 0;
      while (bram_start && n < 100) begin
         tick();
         n++;
      end
      chk("t2_start_len", n, 4);
      n = 0;
      while (!frame_done && n < 100) begin
         tick();
         n++;
      end
      chk("t2_play_len", n, 16);
      chk("t2_count", frame_count, 1);
      chk("t2_ready", in_ready, 1);
      chk("t2_busy", busy, 0);
      tick();
      chk("t2_done_pulse", frame_done, 0);

      // test 3: toggled valid, accepted samples (6j+5)&15
      for (int i = 0; i < 15; i++) begin
         in_valid = (i % 2 == 0);
         in_data = 4'(3 * i + 5);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         v = 4'(6 * k + 5);
         chk("t3_load", bram_load, 1);
         chk("t3_data", bram_data, v);
         tick();
      end
      chk("t3_load_off", bram_load, 0);
      wait_sig("t3_done", 1'b1, 1'b1);
      chk("t3_count", frame_count, 2);

      // test 4: abort on third load cycle, then a clean frame
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data = 4'(i + 8);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      chk("t4_l2_data", bram_data, 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_abort_load", bram_load, 0);
      chk("t4_abort_data", bram_data, 0);
      chk("t4_abort_busy", busy, 0);
      chk("t4_abort_ready", in_ready, 1);
      chk("t4_abort_count", frame_count, 2);
      in_valid = 1'b1;
      in_data = 4'd9;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_drop_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) begin
         in_data = 4'(5 * i + 2);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         v = 4'(5 * k + 2);
         chk("t4_load", bram_load, 1);
         chk("t4_data", bram_data, v);
         tick();
      end
      wait_sig("t4_done", 1'b1, 1'b1);
      chk("t4_count", frame_count, 3);

      // test 5: counter wrap, then abort on last play cycle
      in_valid = 1'b1;
      in_data = 4'd6;
      for (int f = 0; f < 252; f++) begin
         tick();
         wait_sig("t5_done", 1'b1, 1'b1);
      end
      chk("t5_count_255", frame_count, 255);
      tick();
      wait_sig("t5_done_wrap", 1'b1, 1'b1);
      chk("t5_count_wrap", frame_count, 0);
      tick();
      wait_sig("t5_start_hi", 1'b0, 1'b1);
      wait_sig("t5_start_lo", 1'b0, 1'b0);
      repeat (15) tick();
      chk("t5_last_play_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_no_done", frame_done, 0);
      chk("t5_count_kept", frame_count, 0);
      chk("t5_abort_ready", in_ready, 1);
      chk("t5_abort_busy", busy, 0);
      tick();
      chk("t5_no_late_done", frame_done, 0);
      wait_sig("t5_done_next", 1'b1, 1'b1);
      chk("t5_count_one", frame_count, 1);

      // test 6: reset during start
      tick();
      wait_sig("t6_start", 1'b0, 1'b1);
      rst = 1'b0;
      tick();
      chk("t6_start_off", bram_start, 0);
      chk("t6_count_clr", frame_count, 0);
      chk("t6_ready_low", in_ready, 0);
      chk("t6_busy", busy, 0);
      tick();
      chk("t6_ready_held", in_ready, 0);
      rst = 1'b1;
      tick();
      chk("t6_ready_back", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
